// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising x^4+x^3+1 PRBS checker with error counting
// Optional bit_count output (BER denominator) enabled by `define PRBS_CHK_BITCNT_EN.
module prbs_checker #(
    parameter int LOCK_CNT   = 8,
    parameter int WINDOW     = 16,
    parameter int UNLOCK_ERR = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             data_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_loss,
`ifdef PRBS_CHK_BITCNT_EN
    output logic [31:0]      bit_count,
`endif
    output logic [ERR_W-1:0] err_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(UNLOCK_ERR + 1);
    localparam logic [MW-1:0] LOCK_V   = MW'(LOCK_CNT);
    localparam logic [WW-1:0] LAST_W   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] UNLOCK_V = EW'(UNLOCK_ERR);

    typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

    state_t         state;
    logic [3:0]     hist;
    logic [1:0]     seed_cnt;
    logic [MW-1:0]  match_cnt;
    logic [WW-1:0]  win_cnt;
    logic [EW-1:0]  win_err;

    logic           exp_bit;
    logic           err_bit;
    logic [MW-1:0]  match_inc;
    logic [EW-1:0]  win_err_inc;

    assign exp_bit     = hist[3] ^ hist[0];
    assign err_bit     = data_in ^ exp_bit;
    assign match_inc   = match_cnt + MW'(1);
    assign win_err_inc = win_err + EW'(err_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            hist      <= 4'd0;
            seed_cnt  <= 2'd0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            sync_loss <= 1'b0;
            err_count <= '0;
`ifdef PRBS_CHK_BITCNT_EN
            bit_count <= '0;
`endif
        end else begin
            err_pulse <= 1'b0;
            sync_loss <= 1'b0;
            if (valid_in) begin
                case (state)
                    SEED: begin
                        hist     <= {hist[2:0], data_in};
                        seed_cnt <= seed_cnt + 2'd1;
                        if (seed_cnt == 2'd3) begin
                            state     <= HUNT;
                            match_cnt <= '0;
                        end
                    end
                    HUNT: begin
                        hist <= {hist[2:0], data_in};
                        // An all-zero history predicts zeros forever, so it proves nothing
                        if (hist == 4'd0 || err_bit) begin
                            match_cnt <= '0;
                        end else if (match_inc == LOCK_V) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_inc;
                        end
                    end
                    LOCKED: begin
                        // Flywheel on the prediction so a line error is counted once
                        hist <= {hist[2:0], exp_bit};
`ifdef PRBS_CHK_BITCNT_EN
                        if (bit_count != '1)
                            bit_count <= bit_count + 32'd1;
`endif
                        if (err_bit) begin
                            err_pulse <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + ERR_W'(1);
                        end
                        if (err_bit && win_err_inc == UNLOCK_V) begin
                            state     <= SEED;
                            locked    <= 1'b0;
                            sync_loss <= 1'b1;
                            hist      <= 4'd0;
                            seed_cnt  <= 2'd0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else if (win_cnt == LAST_W) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                            win_err <= win_err_inc;
                        end
                    end
                    default: state <= SEED;
                endcase
            end
            if (clr_err) begin
                err_count <= '0;
`ifdef PRBS_CHK_BITCNT_EN
                bit_count <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed self-checking bench for prbs_checker
module tb_prbs_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic data_in = 1'b0;
    logic clr_err = 1'b0;
    logic locked, err_pulse, sync_loss;
    logic [15:0] err_count;
    logic locked2, err_pulse2, sync_loss2;
    logic [3:0] err_count2;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_count, bit_count2;
`endif

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
        .sync_loss(sync_loss),
`ifdef PRBS_CHK_BITCNT_EN
        .bit_count(bit_count),
`endif
        .err_count(err_count)
    );

    prbs_checker #(.ERR_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .clr_err(clr_err), .locked(locked2), .err_pulse(err_pulse2),
        .sync_loss(sync_loss2),
`ifdef PRBS_CHK_BITCNT_EN
        .bit_count(bit_count2),
`endif
        .err_count(err_count2)
    );

    bit pat [0:14] = '{0,0,0,1,1,1,1,0,1,0,1,1,0,0,1};
    int idx = 0;
    int passed = 0;
    int total = 0;
    int ep_cnt = 0;
    int sl_cnt = 0;
    int sl2_cnt = 0;
    int ep2_cnt = 0;
    logic lk_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step_raw(input logic v, input logic d, input logic clr = 1'b0);
        valid_in = v;
        data_in  = d;
        clr_err  = clr;
        @(posedge clk);
        #1;
        ep_cnt  += int'(err_pulse);
        sl_cnt  += int'(sync_loss);
        ep2_cnt += int'(err_pulse2);
        sl2_cnt += int'(sync_loss2);
        lk_seen  = lk_seen | locked;
        valid_in = 1'b0;
        data_in  = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic step(input logic v, input logic flip, input logic clr = 1'b0);
        logic d;
        d = 1'b0;
        if (v) begin
            d   = pat[idx] ^ flip;
            idx = (idx + 1) % 15;
        end
        step_raw(v, d, clr);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_sync_loss", 32'(sync_loss), 0);
        check("rst_err_count", 32'(err_count), 0);
        rst_n = 1'b1;

        // Clean lock: 4 seed + 8 matches
        clean(11);
        check("lock_not_yet_11", 32'(locked), 0);
        clean(1);
        check("lock_at_12", 32'(locked), 1);
        ep_cnt = 0;
        clean(88);
        check("clean_err_count", 32'(err_count), 0);
        check("clean_err_pulses", 32'(ep_cnt), 0);
        check("clean_locked", 32'(locked), 1);

        // Single error at window position 8
        ep_cnt = 0;
        step(1'b1, 1'b1);
        check("single_err_pulse", 32'(err_pulse), 1);
        check("single_err_count", 32'(err_count), 1);
        check("single_locked", 32'(locked), 1);
        clean(5);
        check("single_pulses", 32'(ep_cnt), 1);
        check("single_count_hold", 32'(err_count), 1);
        clean(2);

        step(1'b0, 1'b0, 1'b1);
        check("clr_idle", 32'(err_count), 0);

        // Window boundary: 2 errors at end of window k, 2 at start of k+1
        sl_cnt = 0;
        clean(14);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("bound_sync_loss", 32'(sl_cnt), 0);
        check("bound_err_count", 32'(err_count), 4);
        check("bound_locked", 32'(locked), 1);
        clean(14);

        // Loss of lock: three errors in one window
        step(1'b1, 1'b1);
        clean(4);
        step(1'b1, 1'b1);
        clean(4);
        check("loss_pre_locked", 32'(locked), 1);
        step(1'b1, 1'b1);
        check("loss_sync_loss", 32'(sync_loss), 1);
        check("loss_err_pulse", 32'(err_pulse), 1);
        check("loss_locked", 32'(locked), 0);
        check("loss_err_count", 32'(err_count), 7);
        clean(1);
        check("loss_pulse_end", 32'(sync_loss), 0);
        clean(10);
        check("relock_11", 32'(locked), 0);
        clean(1);
        check("relock_12", 32'(locked), 1);

        // clr_err coincident with an error
        step(1'b1, 1'b1, 1'b1);
        check("clr_coinc_count", 32'(err_count), 0);
        check("clr_coinc_pulse", 32'(err_pulse), 1);
        clean(15);

        // Asynchronous reset while locked
        rst_n = 1'b0;
        #1;
        check("async_rst_locked", 32'(locked), 0);
        @(posedge clk);
        #1;
        check("rst_mid_locked", 32'(locked), 0);
        check("rst_mid_err_count", 32'(err_count), 0);
        check("rst_mid_pulses", 32'({err_pulse, sync_loss}), 0);
        rst_n = 1'b1;

        // Lockup: all-zero input never locks
        lk_seen = 1'b0;
        for (int i = 0; i < 30; i++) step_raw(1'b1, 1'b0);
        check("lockup_locked", 32'(lk_seen), 0);

        // Gapped stream: locks after 12 valid bits
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ep_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        check("gap_not_locked", 32'(locked), 0);
        step(1'b1, 1'b0);
        check("gap_locked_23", 32'(locked), 1);
        step(1'b0, 1'b0);
        check("gap_locked_24", 32'(locked), 1);
        check("gap_no_pulses", 32'(ep_cnt), 0);

        // Saturation: 18 errors, two per window at positions 14 and 15
        step(1'b0, 1'b0, 1'b1);
        sl_cnt = 0;
        sl2_cnt = 0;
        ep2_cnt = 0;
        for (int w = 0; w < 9; w++) begin
            clean(14);
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
        end
        check("sat_wide_count", 32'(err_count), 18);
        check("sat_narrow_count", 32'(err_count2), 15);
        check("sat_narrow_locked", 32'(locked2), 1);
        check("sat_sync_loss", 32'(sl_cnt + sl2_cnt), 0);
        check("sat_narrow_pulses", 32'(ep2_cnt), 18);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
